// File: rtl/uart_tx_fifo_drain.sv
// uart_tx_fifo_drain
//   Serial transmitter placed directly after an 8-bit synchronous FIFO.
//   Pops one byte at a time through the FIFO read port and sends it as a
//   UART frame: start bit, 8 data bits LSB first, optional parity bit,
//   then 1 or 2 stop bits. While enable is high it keeps draining the FIFO
//   frame after frame.
//
// Parameters
//   CLKS_PER_BIT  clk cycles per serial bit (>= 2)
//   PARITY_EN     1 = insert a parity bit after the data bits
//   PARITY_ODD    0 = even parity, 1 = odd parity
//   STOP_BITS     number of stop bits (1 or 2)
//
// Ports
//   clk         clock, all logic on the rising edge
//   rst         synchronous active-high reset
//   enable      allows new frames to start
//   fifo_empty  FIFO empty flag, only looked at while idle
//   fifo_data   FIFO read data, valid the cycle after fifo_rd_en
//   fifo_rd_en  one-cycle FIFO read strobe per byte (registered)
//   tx          serial line, idle high (registered)
//   busy        high whenever a byte is being fetched or sent (registered)
//   byte_done   one-cycle pulse on the last cycle of each frame (registered)
module uart_tx_fifo_drain #(
  parameter int CLKS_PER_BIT = 868,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       fifo_empty,
  input  logic [7:0] fifo_data,
  output logic       fifo_rd_en,
  output logic       tx,
  output logic       busy,
  output logic       byte_done
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
  // byte_done is registered, so it is raised one cycle before the final cycle
  localparam logic [CW-1:0] BAUD_PRE  = CW'(CLKS_PER_BIT - 2);
  localparam logic          STOP_LAST = (STOP_BITS == 2) ? 1'b1 : 1'b0;
  localparam logic          PAR_EN    = (PARITY_EN != 0) ? 1'b1 : 1'b0;
  localparam logic          PAR_ODD   = (PARITY_ODD != 0) ? 1'b1 : 1'b0;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    LOAD   = 3'd2,
    START  = 3'd3,
    DATA   = 3'd4,
    PARITY = 3'd5,
    STOP   = 3'd6
  } state_t;

  // Parity of a data byte; odd selects inversion of the XOR reduction
  function automatic logic parity_of(input logic [7:0] d, input logic odd);
    return (^d) ^ odd;
  endfunction

  state_t        state_r;
  logic [CW-1:0] baud_r;
  logic [2:0]    bit_idx_r;
  logic          stop_idx_r;
  logic [7:0]    shift_r;
  logic          parity_r;
  logic          tx_r;
  logic          rd_en_r;
  logic          busy_r;
  logic          done_r;
  logic          bit_end_s;

  assign bit_end_s = (baud_r == BAUD_LAST);

  // Frame sequencer: state, baud counter, shift register and all outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      baud_r     <= '0;
      bit_idx_r  <= 3'd0;
      stop_idx_r <= 1'b0;
      shift_r    <= 8'h00;
      parity_r   <= 1'b0;
      tx_r       <= 1'b1;
      rd_en_r    <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      rd_en_r <= 1'b0;
      done_r  <= 1'b0;
      case (state_r)
        IDLE: begin
          baud_r     <= '0;
          bit_idx_r  <= 3'd0;
          stop_idx_r <= 1'b0;
          tx_r       <= 1'b1;
          if (enable && !fifo_empty) begin
            state_r <= FETCH;
            rd_en_r <= 1'b1;
            busy_r  <= 1'b1;
          end else begin
            busy_r  <= 1'b0;
          end
        end
        FETCH: begin
          state_r <= LOAD;
        end
        LOAD: begin
          shift_r  <= fifo_data;
          parity_r <= parity_of(fifo_data, PAR_ODD);
          baud_r   <= '0;
          tx_r     <= 1'b0;
          state_r  <= START;
        end
        START: begin
          if (bit_end_s) begin
            baud_r    <= '0;
            bit_idx_r <= 3'd0;
            tx_r      <= shift_r[0];
            state_r   <= DATA;
          end else begin
            baud_r <= baud_r + CW'(1);
          end
        end
        DATA: begin
          if (bit_end_s) begin
            baud_r  <= '0;
            shift_r <= {1'b0, shift_r[7:1]};
            if (bit_idx_r == 3'd7) begin
              if (PAR_EN) begin
                tx_r    <= parity_r;
                state_r <= PARITY;
              end else begin
                tx_r       <= 1'b1;
                stop_idx_r <= 1'b0;
                state_r    <= STOP;
              end
            end else begin
              bit_idx_r <= bit_idx_r + 3'd1;
              // next data bit is the one above the bit currently on the line
              tx_r      <= shift_r[1];
            end
          end else begin
            baud_r <= baud_r + CW'(1);
          end
        end
        PARITY: begin
          if (bit_end_s) begin
            baud_r     <= '0;
            tx_r       <= 1'b1;
            stop_idx_r <= 1'b0;
            state_r    <= STOP;
          end else begin
            baud_r <= baud_r + CW'(1);
          end
        end
        STOP: begin
          tx_r <= 1'b1;
          if (baud_r == BAUD_PRE && stop_idx_r == STOP_LAST) begin
            done_r <= 1'b1;
          end
          if (bit_end_s) begin
            baud_r <= '0;
            if (stop_idx_r == STOP_LAST) begin
              busy_r  <= 1'b0;
              state_r <= IDLE;
            end else begin
              stop_idx_r <= 1'b1;
            end
          end else begin
            baud_r <= baud_r + CW'(1);
          end
        end
        default: begin
          state_r    <= IDLE;
          baud_r     <= '0;
          bit_idx_r  <= 3'd0;
          stop_idx_r <= 1'b0;
          tx_r       <= 1'b1;
          busy_r     <= 1'b0;
        end
      endcase
    end
  end

  assign fifo_rd_en = rd_en_r;
  assign tx         = tx_r;
  assign busy       = busy_r;
  assign byte_done  = done_r;

endmodule

// File: tb/tb_uart_tx_fifo_drain.sv
// Bench for uart_tx_fifo_drain. Three instances share clk/rst/enable:
//   inst0: no parity, 1 stop; inst1: even parity, 1 stop; inst2: odd parity, 2 stops.
// Each instance is fed by a small FIFO model; line activity is recorded per
// cycle and compared against frames computed from the UART framing rules.
module tb_uart_tx_fifo_drain;

  localparam int CPB   = 4;
  localparam int NI    = 3;
  localparam int TRMAX = 1024;
  localparam int PE [NI] = '{0, 1, 1};
  localparam int PO [NI] = '{0, 0, 1};
  localparam int SB [NI] = '{1, 1, 2};

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       fe  [NI];
  logic [7:0] fd  [NI];
  logic       rd  [NI];
  logic       txo [NI];
  logic       bsy [NI];
  logic       bdn [NI];

  // FIFO model storage: bench writes fmem/wp, FIFO process advances rp
  logic [7:0] fmem [NI][128];
  int         wp [NI] = '{0, 0, 0};
  int         rp [NI] = '{0, 0, 0};
  int         rd_on_empty = 0;

  // per-cycle traces and expected traces
  logic tx_tr [NI][TRMAX];
  logic rd_tr [NI][TRMAX];
  logic bd_tr [NI][TRMAX];
  logic bs_tr [NI][TRMAX];
  logic exp_tx [TRMAX];
  logic exp_bd [TRMAX];
  logic exp_bs [TRMAX];
  int   ntr;
  int   base [NI];
  int   pp [64];
  int   npulse, nhigh;

  int n_run  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  uart_tx_fifo_drain #(.CLKS_PER_BIT(CPB), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u0 (
    .clk(clk), .rst(rst), .enable(en), .fifo_empty(fe[0]), .fifo_data(fd[0]),
    .fifo_rd_en(rd[0]), .tx(txo[0]), .busy(bsy[0]), .byte_done(bdn[0]));
  uart_tx_fifo_drain #(.CLKS_PER_BIT(CPB), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u1 (
    .clk(clk), .rst(rst), .enable(en), .fifo_empty(fe[1]), .fifo_data(fd[1]),
    .fifo_rd_en(rd[1]), .tx(txo[1]), .busy(bsy[1]), .byte_done(bdn[1]));
  uart_tx_fifo_drain #(.CLKS_PER_BIT(CPB), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(2)) u2 (
    .clk(clk), .rst(rst), .enable(en), .fifo_empty(fe[2]), .fifo_data(fd[2]),
    .fifo_rd_en(rd[2]), .tx(txo[2]), .busy(bsy[2]), .byte_done(bdn[2]));

  // Synchronous FIFO model: data valid the cycle after a read, registered
  // empty flag, and random garbage on the data bus whenever no read happens
  always @(posedge clk) begin
    for (int i = 0; i < NI; i++) begin
      if (rd[i] === 1'b1 && rp[i] == wp[i]) begin
        rd_on_empty <= rd_on_empty + 1;
        fd[i] <= 8'($urandom);
        fe[i] <= 1'b1;
      end else if (rd[i] === 1'b1) begin
        fd[i] <= fmem[i][rp[i]];
        rp[i] <= rp[i] + 1;
        fe[i] <= ((rp[i] + 1) == wp[i]);
      end else begin
        fd[i] <= 8'($urandom);
        fe[i] <= (rp[i] == wp[i]);
      end
    end
  end

  function automatic int frame_len(input int i);
    return CPB * (9 + PE[i] + SB[i]);
  endfunction

  // k-th bit slot of a frame: start, 8 data LSB first, parity, stops
  function automatic logic frame_bit(input int i, input logic [7:0] b, input int k);
    if (k == 0) return 1'b0;
    if (k <= 8) return b[k-1];
    if (k == 9 && PE[i] != 0) return (^b) ^ (PO[i] != 0);
    return 1'b1;
  endfunction

  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      for (int i = 0; i < NI; i++) begin
        tx_tr[i][ntr] = txo[i];
        rd_tr[i][ntr] = rd[i];
        bd_tr[i][ntr] = bdn[i];
        bs_tr[i][ntr] = bsy[i];
      end
      if (ntr < TRMAX - 1) ntr++;
    end
  endtask

  task automatic new_window();
    ntr = 0;
    for (int i = 0; i < NI; i++) base[i] = rp[i];
  endtask

  task automatic push(input int i, input logic [7:0] b);
    fmem[i][wp[i]] = b;
    wp[i] = wp[i] + 1;
  endtask

  task automatic wait_pulse(input int i, output int p, output bit ok);
    ok = 1'b0;
    p  = -1;
    for (int k = 0; k < 40 && !ok; k++) begin
      step(1);
      if (rd_tr[i][ntr-1] === 1'b1) begin
        ok = 1'b1;
        p  = ntr - 1;
      end
    end
  endtask

  // Reference model: each read pulse starts a frame two cycles later carrying
  // the next byte held in the FIFO; busy covers fetch through the last stop.
  task automatic build_expect(input int i);
    int s;
    int len;
    logic [7:0] b;
    npulse = 0;
    nhigh  = 0;
    for (int c = 0; c < ntr; c++) begin
      exp_tx[c] = 1'b1;
      exp_bd[c] = 1'b0;
      exp_bs[c] = 1'b0;
      if (rd_tr[i][c] === 1'b1) begin
        nhigh++;
        if (c == 0 || rd_tr[i][c-1] !== 1'b1) begin
          pp[npulse] = c;
          npulse++;
        end
      end
    end
    len = frame_len(i);
    for (int j = 0; j < npulse; j++) begin
      b = fmem[i][base[i] + j];
      s = pp[j] + 2;
      for (int c = pp[j]; c < s + len && c < ntr; c++) exp_bs[c] = 1'b1;
      for (int k = 0; k < len && s + k < ntr; k++) exp_tx[s+k] = frame_bit(i, b, k / CPB);
      if (s + len - 1 < ntr) exp_bd[s+len-1] = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    en  = 1'b0;
    new_window();
    step(2);
    for (int i = 0; i < NI; i++) begin
      n_run++;
      if (txo[i] !== 1'b1) begin n_fail++; $display("FAIL reset_tx inst%0d: got %b want 1", i, txo[i]); end
      n_run++;
      if (bsy[i] !== 1'b0) begin n_fail++; $display("FAIL reset_busy inst%0d: got %b want 0", i, bsy[i]); end
      n_run++;
      if (rd[i] !== 1'b0) begin n_fail++; $display("FAIL reset_rd_en inst%0d: got %b want 0", i, rd[i]); end
      n_run++;
      if (bdn[i] !== 1'b0) begin n_fail++; $display("FAIL reset_byte_done inst%0d: got %b want 0", i, bdn[i]); end
    end
    rst = 1'b0;
    step(3);
  endtask

  task automatic test_single_a5();
    logic [9:0] a5_bits = 10'b1101001010;
    int f, bdi, bad, first;
    new_window();
    push(0, 8'hA5);
    en = 1'b1;
    step(60);
    build_expect(0);
    n_run++;
    if (npulse != 1 || nhigh != 1) begin
      n_fail++; $display("FAIL a5_rd_en: got %0d pulses/%0d high cycles want 1/1", npulse, nhigh);
    end
    f = -1; bdi = -1;
    for (int c = 0; c < ntr; c++) begin
      if (f < 0 && tx_tr[0][c] === 1'b0) f = c;
      if (bdi < 0 && bd_tr[0][c] === 1'b1) bdi = c;
    end
    n_run++;
    if (npulse < 1 || f != pp[0] + 2) begin
      n_fail++; $display("FAIL a5_start_latency: start edge at %0d, rd_en at %0d, want +2", f, pp[0]);
    end
    if (f >= 0) begin
      for (int k = 0; k < 10; k++) begin
        n_run++;
        if (tx_tr[0][f + k*CPB + 2] !== a5_bits[k]) begin
          n_fail++; $display("FAIL a5_bit%0d: got %b want %b", k, tx_tr[0][f + k*CPB + 2], a5_bits[k]);
        end
      end
    end
    n_run++;
    if (f < 0 || bdi - f + 1 != 40) begin
      n_fail++; $display("FAIL a5_frame_len: got %0d want 40", bdi - f + 1);
    end
    bad = 0; first = 0;
    for (int c = 0; c < ntr; c++)
      if (tx_tr[0][c] !== exp_tx[c] || bd_tr[0][c] !== exp_bd[c] || bs_tr[0][c] !== exp_bs[c]) begin
        if (bad == 0) first = c;
        bad++;
      end
    n_run++;
    if (bad != 0) begin
      n_fail++; $display("FAIL a5_trace: %0d cycles differ, first %0d tx %b/%b bd %b/%b busy %b/%b (got/want)",
        bad, first, tx_tr[0][first], exp_tx[first], bd_tr[0][first], exp_bd[first], bs_tr[0][first], exp_bs[first]);
    end
  endtask

  task automatic test_parity();
    int f, bdi, bad, first;
    logic par_want;
    new_window();
    push(1, 8'h07);
    push(2, 8'h07);
    en = 1'b1;
    step(80);
    for (int i = 1; i < NI; i++) begin
      build_expect(i);
      par_want = (i == 1) ? 1'b1 : 1'b0;
      f = -1; bdi = -1;
      for (int c = 0; c < ntr; c++) begin
        if (f < 0 && tx_tr[i][c] === 1'b0) f = c;
        if (bdi < 0 && bd_tr[i][c] === 1'b1) bdi = c;
      end
      n_run++;
      if (f < 0 || tx_tr[i][f + 9*CPB + 2] !== par_want) begin
        n_fail++; $display("FAIL parity_bit inst%0d: got %b want %b", i, (f < 0) ? 1'bx : tx_tr[i][f + 9*CPB + 2], par_want);
      end
      n_run++;
      if (f < 0 || bdi - f + 1 != ((i == 1) ? 44 : 48)) begin
        n_fail++; $display("FAIL parity_frame_len inst%0d: got %0d want %0d", i, bdi - f + 1, (i == 1) ? 44 : 48);
      end
      bad = 0; first = 0;
      for (int c = 0; c < ntr; c++)
        if (tx_tr[i][c] !== exp_tx[c] || bd_tr[i][c] !== exp_bd[c] || bs_tr[i][c] !== exp_bs[c]) begin
          if (bad == 0) first = c;
          bad++;
        end
      n_run++;
      if (bad != 0 || npulse != 1) begin
        n_fail++; $display("FAIL parity_trace inst%0d: %0d cycles differ (first %0d), %0d pulses want 1", i, bad, first, npulse);
      end
    end
  endtask

  task automatic test_back_to_back();
    int bad, first, gap;
    new_window();
    push(0, 8'h11);
    push(0, 8'h22);
    push(0, 8'h33);
    en = 1'b1;
    step(160);
    build_expect(0);
    n_run++;
    if (npulse != 3 || nhigh != 3) begin
      n_fail++; $display("FAIL b2b_rd_en: got %0d pulses/%0d high want 3/3", npulse, nhigh);
    end
    for (int j = 1; j < npulse; j++) begin
      // idle-high cycles between end of previous stop bit and next start bit
      gap = (pp[j] + 2) - (pp[j-1] + 2 + frame_len(0));
      n_run++;
      if (gap != 3) begin n_fail++; $display("FAIL b2b_gap%0d: got %0d want 3", j, gap); end
    end
    bad = 0; first = 0;
    for (int c = 0; c < ntr; c++)
      if (tx_tr[0][c] !== exp_tx[c] || bd_tr[0][c] !== exp_bd[c] || bs_tr[0][c] !== exp_bs[c]) begin
        if (bad == 0) first = c;
        bad++;
      end
    n_run++;
    if (bad != 0) begin n_fail++; $display("FAIL b2b_trace: %0d cycles differ, first %0d", bad, first); end
    n_run++;
    if (bsy[0] !== 1'b0 || fe[0] !== 1'b1) begin
      n_fail++; $display("FAIL b2b_idle: busy %b empty %b want 0/1", bsy[0], fe[0]);
    end
  endtask

  task automatic test_enable_drop();
    int p, bad, first, nbd;
    bit ok;
    new_window();
    push(0, 8'h44);
    push(0, 8'h55);
    en = 1'b1;
    wait_pulse(0, p, ok);
    n_run++;
    if (!ok) begin n_fail++; $display("FAIL endrop_first_fetch: no rd_en within bound"); end
    step(19);           // now inside data bit 3
    en = 1'b0;
    step(60);
    build_expect(0);
    nbd = 0;
    for (int c = 0; c < ntr; c++) if (bd_tr[0][c] === 1'b1) nbd++;
    n_run++;
    if (npulse != 1 || nbd != 1) begin
      n_fail++; $display("FAIL endrop_hold: got %0d pulses %0d byte_done want 1/1", npulse, nbd);
    end
    bad = 0; first = 0;
    for (int c = 0; c < ntr; c++)
      if (tx_tr[0][c] !== exp_tx[c] || bd_tr[0][c] !== exp_bd[c] || bs_tr[0][c] !== exp_bs[c]) begin
        if (bad == 0) first = c;
        bad++;
      end
    n_run++;
    if (bad != 0) begin n_fail++; $display("FAIL endrop_trace: %0d cycles differ, first %0d", bad, first); end
    new_window();
    en = 1'b1;
    step(70);
    build_expect(0);
    bad = 0;
    for (int c = 0; c < ntr; c++)
      if (tx_tr[0][c] !== exp_tx[c] || bd_tr[0][c] !== exp_bd[c]) bad++;
    n_run++;
    if (npulse != 1 || bad != 0) begin
      n_fail++; $display("FAIL endrop_resume: got %0d pulses %0d bad cycles want 1/0", npulse, bad);
    end
  endtask

  task automatic test_reset_mid_frame();
    int p, bad, nbd;
    bit ok;
    new_window();
    push(0, 8'h66);
    push(0, 8'h77);
    en = 1'b1;
    wait_pulse(0, p, ok);
    n_run++;
    if (!ok) begin n_fail++; $display("FAIL rstmid_first_fetch: no rd_en within bound"); end
    step(27);           // now inside data bit 5
    rst = 1'b1;
    step(1);
    n_run++;
    if (tx_tr[0][ntr-1] !== 1'b1 || bs_tr[0][ntr-1] !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_abort: tx %b busy %b want 1/0", tx_tr[0][ntr-1], bs_tr[0][ntr-1]);
    end
    rst = 1'b0;
    nbd = 0;
    for (int c = 0; c < ntr; c++) if (bd_tr[0][c] === 1'b1) nbd++;
    n_run++;
    if (nbd != 0) begin n_fail++; $display("FAIL rstmid_no_done: got %0d byte_done want 0", nbd); end
    new_window();
    step(70);
    build_expect(0);
    bad = 0;
    for (int c = 0; c < ntr; c++)
      if (tx_tr[0][c] !== exp_tx[c] || bd_tr[0][c] !== exp_bd[c] || bs_tr[0][c] !== exp_bs[c]) bad++;
    n_run++;
    if (npulse != 1 || bad != 0 || fmem[0][base[0]] !== 8'h77) begin
      n_fail++; $display("FAIL rstmid_refetch: got %0d pulses %0d bad cycles want 1/0", npulse, bad);
    end
  endtask

  task automatic test_random();
    int nb [NI];
    int bad, first;
    for (int r = 0; r < 3; r++) begin
      new_window();
      for (int i = 0; i < NI; i++) begin
        nb[i] = $urandom_range(1, 3);
        for (int k = 0; k < nb[i]; k++) push(i, 8'($urandom));
      end
      en = 1'b1;
      step(220);
      for (int i = 0; i < NI; i++) begin
        build_expect(i);
        n_run++;
        if (npulse != nb[i] || nhigh != nb[i]) begin
          n_fail++; $display("FAIL rand_r%0d_rd_en inst%0d: got %0d pulses want %0d", r, i, npulse, nb[i]);
        end
        for (int j = 1; j < npulse; j++) begin
          n_run++;
          if (pp[j] - pp[j-1] != frame_len(i) + 3) begin
            n_fail++; $display("FAIL rand_r%0d_spacing inst%0d: got %0d want %0d", r, i, pp[j] - pp[j-1], frame_len(i) + 3);
          end
        end
        bad = 0; first = 0;
        for (int c = 0; c < ntr; c++)
          if (tx_tr[i][c] !== exp_tx[c] || bd_tr[i][c] !== exp_bd[c] || bs_tr[i][c] !== exp_bs[c]) begin
            if (bad == 0) first = c;
            bad++;
          end
        n_run++;
        if (bad != 0) begin
          n_fail++; $display("FAIL rand_r%0d_trace inst%0d: %0d cycles differ, first %0d tx %b/%b (got/want)",
            r, i, bad, first, tx_tr[i][first], exp_tx[first]);
        end
      end
    end
  endtask

  task automatic test_no_read_on_empty();
    n_run++;
    if (rd_on_empty != 0) begin
      n_fail++; $display("FAIL rd_en_on_empty: got %0d reads while empty want 0", rd_on_empty);
    end
  endtask

  initial begin
    rst = 1'b1;
    en  = 1'b0;
    ntr = 0;
    test_reset();
    test_single_a5();
    test_parity();
    test_back_to_back();
    test_enable_drop();
    test_reset_mid_frame();
    test_random();
    test_no_read_on_empty();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
